// File: rtl/mte_pkg.sv
// Shared constants, FSM state type and the canonical MAC-then-encrypt transforms.
package mte_pkg;

  localparam int         MTE_W   = 8;
  localparam logic [7:0] MAC_XOR = 8'h5A;
  localparam int         ROT     = 3;

  typedef enum logic [1:0] {
    S_DATA  = 2'd0,
    S_MAC   = 2'd1,
    S_CHECK = 2'd2,
    S_OUT   = 2'd3
  } mte_rx_state_t;

  function automatic logic [7:0] mte_encrypt(input logic [7:0] p, input logic [7:0] k);
    logic [7:0] x;
    x = p ^ k;
    return {x[7-ROT:0], x[7:8-ROT]};
  endfunction

  function automatic logic [7:0] mte_decrypt(input logic [7:0] c, input logic [7:0] k);
    return {c[ROT-1:0], c[7:ROT]} ^ k;
  endfunction

  // Sum wraps mod 256 because the result is truncated to 8 bits.
  function automatic logic [7:0] mte_mac(input logic [7:0] d, input logic [7:0] k);
    logic [7:0] s;
    s = d + k;
    return s ^ MAC_XOR;
  endfunction

endpackage

// File: rtl/mte_rx_check.sv
// Combinational frame check: decrypt both cipher bytes, regenerate the MAC and compare.
module mte_rx_check
  import mte_pkg::*;
(
  input  logic [MTE_W-1:0] cd,
  input  logic [MTE_W-1:0] cm,
  input  logic [MTE_W-1:0] k,
  output logic [MTE_W-1:0] pd,
  output logic             eq
);

  logic [MTE_W-1:0] pm;

  assign pd = mte_decrypt(cd, k);
  assign pm = mte_decrypt(cm, k);
  assign eq = (mte_mac(pd, k) == pm);

endmodule

// File: rtl/mte_receiver.sv
// Receive side of the MAC-then-encrypt link: collects a two-byte cipher frame,
// authenticates it and presents plaintext (or a zeroed failure) on a valid/ready port.
module mte_receiver
  import mte_pkg::*;
#(
  parameter int W = MTE_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] key,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] OUT,
  output logic         valid_key,
  output logic [7:0]   err_count
);

  mte_rx_state_t state_q, state_d;

  logic [W-1:0] cd_q, cd_d;
  logic [W-1:0] cm_q, cm_d;
  logic [W-1:0] k_l_q, k_l_d;
  logic [W-1:0] out_q, out_d;
  logic         valid_key_q, valid_key_d;
  logic [7:0]   err_count_q, err_count_d;

  logic [W-1:0] pd;
  logic         eq;

  mte_rx_check u_check (
    .cd (cd_q),
    .cm (cm_q),
    .k  (k_l_q),
    .pd (pd),
    .eq (eq)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DATA:  if (in_valid)  state_d = S_MAC;
      S_MAC:   if (in_valid)  state_d = S_CHECK;
      S_CHECK:                state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_DATA;
      default:                state_d = S_DATA;
    endcase
  end

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_DATA:  in_ready  = 1'b1;
      S_MAC:   in_ready  = 1'b1;
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: key is latched with the data byte and held for the frame.
  always_comb begin
    cd_d        = cd_q;
    cm_d        = cm_q;
    k_l_d       = k_l_q;
    out_d       = out_q;
    valid_key_d = valid_key_q;
    err_count_d = err_count_q;
    case (state_q)
      S_DATA: begin
        if (in_valid) begin
          cd_d  = in_data;
          k_l_d = key;
        end
      end
      S_MAC: begin
        if (in_valid) cm_d = in_data;
      end
      S_CHECK: begin
        out_d       = eq ? pd : '0;
        valid_key_d = eq;
        if (!eq && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cd_q        <= '0;
      cm_q        <= '0;
      k_l_q       <= '0;
      out_q       <= '0;
      valid_key_q <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      cd_q        <= cd_d;
      cm_q        <= cm_d;
      k_l_q       <= k_l_d;
      out_q       <= out_d;
      valid_key_q <= valid_key_d;
      err_count_q <= err_count_d;
    end
  end

  assign OUT       = out_q;
  assign valid_key = valid_key_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mte_receiver.sv
// Directed, table-driven bench for mte_receiver with hand-sequenced reset and saturation cases.
module tb_mte_receiver;
  import mte_pkg::*;

  logic       clock;
  logic       reset;
  logic [7:0] key;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] OUT;
  logic       valid_key;
  logic [7:0] err_count;

  int tests_run;
  int tests_failed;
  int exp_err;

  typedef struct {
    string      name;
    logic [7:0] k_data;
    logic [7:0] k_mac;
    logic [7:0] cd;
    logic [7:0] cm;
    logic [7:0] exp_out;
    logic       exp_vk;
    int         gap;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  mte_receiver #(.W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .key       (key),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT),
    .valid_key (valid_key),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one byte and hold it until the receiver has taken it.
  task automatic send_byte(input string name, input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_in_ready_timeout: got 0 expected 1", name);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input logic quiet);
    logic [7:0] o_snap;
    logic       vk_snap;
    key = v.k_data;
    send_byte(v.name, v.cd);
    key = v.k_mac;
    for (int g = 0; g < v.gap; g++) begin
      check({v.name, "_gap_in_ready"}, {7'd0, in_ready}, 8'd1);
      step();
    end
    send_byte(v.name, v.cm);
    // One cycle in the check state: nothing offered either way.
    check({v.name, "_check_out_valid"}, {7'd0, out_valid}, 8'd0);
    check({v.name, "_check_in_ready"}, {7'd0, in_ready}, 8'd0);
    step();
    if (v.exp_vk == 1'b0 && exp_err != 255) exp_err++;
    check({v.name, "_out_valid"}, {7'd0, out_valid}, 8'd1);
    check({v.name, "_OUT"}, OUT, v.exp_out);
    check({v.name, "_valid_key"}, {7'd0, valid_key}, {7'd0, v.exp_vk});
    check({v.name, "_err_count"}, err_count, exp_err[7:0]);
    o_snap  = OUT;
    vk_snap = valid_key;
    for (int h = 0; h < v.hold; h++) begin
      step();
      check({v.name, "_hold_out_valid"}, {7'd0, out_valid}, 8'd1);
      check({v.name, "_hold_in_ready"}, {7'd0, in_ready}, 8'd0);
      check({v.name, "_hold_OUT"}, OUT, o_snap);
      check({v.name, "_hold_valid_key"}, {7'd0, valid_key}, {7'd0, vk_snap});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({v.name, "_after_in_ready"}, {7'd0, in_ready}, 8'd1);
    check({v.name, "_after_out_valid"}, {7'd0, out_valid}, 8'd0);
    if (!quiet) $display("[TB] frame %s: OUT=%02h valid_key=%0b err_count=%02h",
                         v.name, OUT, valid_key, err_count);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_err      = 0;
    reset     = 1'b1;
    key       = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    //             name        k_data  k_mac  cd     cm     exp_out vk    gap hold
    vecs[0] = '{"auth",       8'h3C, 8'h3C, 8'hEB, 8'hD8, 8'h41, 1'b1, 0, 0};
    vecs[1] = '{"tamper",     8'h3C, 8'h3C, 8'hEB, 8'hD9, 8'h00, 1'b0, 0, 0};
    vecs[2] = '{"zero_pt",    8'h00, 8'h00, 8'h00, 8'hD2, 8'h00, 1'b1, 0, 0};
    vecs[3] = '{"keychg_bp",  8'h3C, 8'hFF, 8'hEB, 8'hD8, 8'h41, 1'b1, 0, 5};
    vecs[4] = '{"mac_wrap",   8'h01, 8'h01, 8'hF7, 8'hDA, 8'hFF, 1'b1, 2, 0};
    vecs[5] = '{"built_ok",   8'hA5, 8'hA5, mte_encrypt(8'h7E, 8'hA5),
                mte_encrypt((8'h7E + 8'hA5) ^ 8'h5A, 8'hA5), 8'h7E, 1'b1, 3, 1};
    vecs[6] = '{"built_bad",  8'hA5, 8'hA5, mte_encrypt(8'h7E, 8'hA5),
                mte_encrypt(8'h00, 8'hA5), 8'h00, 1'b0, 0, 0};
    vecs[7] = '{"auth_again", 8'h3C, 8'h3C, 8'hEB, 8'hD8, 8'h41, 1'b1, 0, 0};

    repeat (3) step();
    reset = 1'b0;
    check("reset_in_ready", {7'd0, in_ready}, 8'd1);
    check("reset_out_valid", {7'd0, out_valid}, 8'd0);
    check("reset_OUT", OUT, 8'h00);
    check("reset_valid_key", {7'd0, valid_key}, 8'd0);
    check("reset_err_count", err_count, 8'h00);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], 1'b0);

    // Reset after only the data byte: frame discarded, counter cleared.
    key = 8'h3C;
    send_byte("midreset", 8'hEB);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_err = 0;
    check("midreset_in_ready", {7'd0, in_ready}, 8'd1);
    check("midreset_out_valid", {7'd0, out_valid}, 8'd0);
    check("midreset_err_count", err_count, 8'h00);
    run_frame(vecs[0], 1'b0);

    // Saturation of the failure counter.
    for (int i = 0; i < 260; i++) run_frame(vecs[1], 1'b1);
    check("sat_err_count", err_count, 8'hFF);
    $display("[TB] saturation: err_count=%02h after 260 tampered frames", err_count);
    run_frame(vecs[0], 1'b0);
    check("sat_after_auth", err_count, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
